// File: rtl/lfsr_crypt_pkg.sv
// Shared types, address map and LFSR helpers for the LFSR encryption stage.
package lfsr_crypt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_PRE,
        LD_PTRN,
        LD_INIT,
        RD,
        WR,
        DONE
    } state_e;

    localparam logic [7:0] MSG_BASE   = 8'd0;
    localparam logic [7:0] PRE_ADDR   = 8'd61;
    localparam logic [7:0] PTRN_ADDR  = 8'd62;
    localparam logic [7:0] INIT_ADDR  = 8'd63;
    localparam logic [7:0] CRYPT_BASE = 8'd64;
    localparam int         NUM_BYTES  = 64;
    localparam logic [7:0] PAD_CHAR   = 8'h20;
    localparam logic [5:0] LAST_IDX   = 6'(NUM_BYTES - 1);

    // Tap patterns that give a maximal-length 7-bit sequence.
    localparam logic [6:0] TAP_PATTERNS [9] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    function automatic logic [6:0] lfsr7_next(input logic [6:0] state, input logic [6:0] taps);
        return {state[5:0], ^(state & taps)};
    endfunction

    function automatic logic parity7(input logic [7:0] data);
        return ^data[6:0];
    endfunction

endpackage

// File: rtl/lfsr7.sv
// 7-bit Fibonacci-style LFSR with load and step; a zero load becomes 7'h01 so the
// sequence can never lock up in the all-zero state.
module lfsr7
    import lfsr_crypt_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       load,
    input  logic [6:0] load_val,
    input  logic       step,
    input  logic [6:0] taps,
    output logic [6:0] value
);

    logic [6:0] value_q;
    logic [6:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = (load_val == 7'h00) ? 7'h01 : load_val;
        end else if (step) begin
            value_d = lfsr7_next(value_q, taps);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            value_q <= 7'h00;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/lfsr_encrypt_engine.sv
// Reads key material and message from data memory, encrypts the 64-byte padded frame
// with an LFSR keystream plus parity bit, and writes the ciphertext to the upper half.
module lfsr_encrypt_engine
    import lfsr_crypt_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Ack,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);

    state_e     state_q, state_d;
    logic       armed_q, armed_d;
    logic [5:0] i_q, i_d;
    logic [3:0] pre_q, pre_d;
    logic [6:0] ptrn_q, ptrn_d;
    logic [6:0] src_q, src_d;

    logic       lfsr_load;
    logic       lfsr_step;
    logic [6:0] lfsr_val;
    logic [6:0] cipher;
    logic       rd_msb_unused;

    // Source bit 7 never reaches the ciphertext, so only bits 6..0 are kept.
    assign rd_msb_unused = mem_rd_data[7];
    assign cipher        = src_q ^ lfsr_val;

    lfsr7 u_lfsr (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (lfsr_load),
        .load_val (mem_rd_data[6:0]),
        .step     (lfsr_step),
        .taps     (ptrn_q),
        .value    (lfsr_val)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        i_d         = i_q;
        pre_d       = pre_q;
        ptrn_d      = ptrn_q;
        src_d       = src_q;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;
        mem_addr    = 8'h00;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'h00;
        Ack         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b0;
                    state_d = LD_PRE;
                end
            end
            LD_PRE: begin
                mem_addr = PRE_ADDR;
                pre_d    = mem_rd_data[3:0];
                state_d  = LD_PTRN;
            end
            LD_PTRN: begin
                mem_addr = PTRN_ADDR;
                ptrn_d   = mem_rd_data[6:0];
                state_d  = LD_INIT;
            end
            LD_INIT: begin
                mem_addr  = INIT_ADDR;
                lfsr_load = 1'b1;
                i_d       = 6'd0;
                state_d   = RD;
            end
            RD: begin
                // The first pre bytes of the frame are preamble, not message.
                if (i_q >= {2'b00, pre_q}) begin
                    mem_addr = MSG_BASE + ({2'b00, i_q} - {4'b0000, pre_q});
                    src_d    = mem_rd_data[6:0];
                end else begin
                    src_d    = PAD_CHAR[6:0];
                end
                state_d = WR;
            end
            WR: begin
                mem_wr_en   = 1'b1;
                mem_addr    = CRYPT_BASE + {2'b00, i_q};
                mem_wr_data = {parity7({1'b0, cipher}), cipher};
                lfsr_step   = 1'b1;
                if (i_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 6'd1;
                    state_d = RD;
                end
            end
            DONE: begin
                Ack = 1'b1;
                if (Start) begin
                    armed_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            i_q     <= 6'd0;
            pre_q   <= 4'd0;
            ptrn_q  <= 7'h00;
            src_q   <= 7'h00;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            i_q     <= i_d;
            pre_q   <= pre_d;
            ptrn_q  <= ptrn_d;
            src_q   <= src_d;
        end
    end

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// Directed bench for lfsr_encrypt_engine: split source/ciphertext memory model,
// hand-computed ciphertext bytes and an independent frame model.
module tb_lfsr_encrypt_engine;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic       Ack;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    logic [7:0] src_mem  [64];
    logic [7:0] ct_mem   [64];
    logic [7:0] exp_ct   [64];
    logic [7:0] saved_ct [64];
    logic [7:0] rd_log   [64];

    logic       ct_clear  = 1'b0;
    int         wr_count  = 0;
    bit         wr_prev   = 1'b0;
    bit         wr_double = 1'b0;
    bit         wr_oob    = 1'b0;
    logic [7:0] prev_addr = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    lfsr_encrypt_engine dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Ack         (Ack),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    always #5 Clk = ~Clk;

    assign mem_rd_data = (mem_addr[7:6] == 2'b00) ? src_mem[mem_addr[5:0]] :
                         (mem_addr[7:6] == 2'b01) ? ct_mem[mem_addr[5:0]]  : 8'h00;

    // Ciphertext half of memory plus write monitors; rd_log keeps the address driven
    // in the cycle before each write, i.e. the source address used for that byte.
    always @(posedge Clk) begin
        if (ct_clear) begin
            for (int k = 0; k < 64; k++) ct_mem[k] <= 8'hEE;
            wr_count  <= 0;
            wr_double <= 1'b0;
            wr_oob    <= 1'b0;
        end else if (mem_wr_en === 1'b1) begin
            if (mem_addr[7:6] == 2'b01) begin
                ct_mem[mem_addr[5:0]] <= mem_wr_data;
                rd_log[mem_addr[5:0]] <= prev_addr;
            end else begin
                wr_oob <= 1'b1;
            end
            wr_count <= wr_count + 1;
            if (wr_prev) wr_double <= 1'b1;
        end
        wr_prev   <= (mem_wr_en === 1'b1);
        prev_addr <= mem_addr;
    end

    task automatic set_msg(input string s);
        for (int k = 0; k < 61; k++) src_mem[k] = (k < s.len()) ? s[k] : 8'h20;
    endtask

    task automatic set_key(input logic [7:0] pre_b, input logic [7:0] ptrn_b, input logic [7:0] init_b);
        src_mem[61] = pre_b;
        src_mem[62] = ptrn_b;
        src_mem[63] = init_b;
    endtask

    task automatic build_model(input logic [3:0] pre, input logic [6:0] ptrn, input logic [6:0] init);
        logic [6:0] lf;
        logic [6:0] c;
        logic [7:0] s;
        lf = (init == 7'h00) ? 7'h01 : init;
        for (int k = 0; k < 64; k++) begin
            s = (k < int'(pre)) ? 8'h20 : src_mem[k - int'(pre)];
            c = s[6:0] ^ lf;
            exp_ct[k] = {^c, c};
            lf = {lf[5:0], ^(lf & ptrn)};
        end
    endtask

    task automatic clear_ct();
        @(negedge Clk);
        ct_clear = 1'b1;
        @(negedge Clk);
        ct_clear = 1'b0;
    endtask

    // Start high then low; lat = edges after the launch edge until Ack is seen, -1 on timeout.
    task automatic launch(output int lat);
        @(negedge Clk);
        Start = 1'b1;
        repeat (2) @(negedge Clk);
        Start = 1'b0;
        lat = -1;
        for (int n = 0; n < 300; n++) begin
            @(posedge Clk);
            #1;
            if (Ack === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Start = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        n_checks++; if (Ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", Ack); end
        n_checks++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", mem_wr_en); end
        n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
        n_checks++; if (mem_wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h want 00", mem_wr_data); end
        Reset = 1'b1;
    endtask

    task automatic test_basic();
        int         lat;
        logic [7:0] hand [7];
        hand = '{8'h21, 8'h22, 8'h24, 8'h28, 8'h30, 8'h00, 8'hE1};
        set_msg("Wads has worked once again");
        set_key(8'hFA, 8'hE0, 8'h81);
        build_model(4'd10, 7'h60, 7'h01);
        clear_ct();
        launch(lat);
        n_checks++; if (lat != 131) begin n_fail++; $display("FAIL basic_latency: got %0d want 131", lat); end
        n_checks++; if (wr_count != 64) begin n_fail++; $display("FAIL basic_writes: got %0d want 64", wr_count); end
        n_checks++; if (wr_double || wr_oob) begin n_fail++; $display("FAIL basic_wr_shape: double=%b oob=%b want 0 0", wr_double, wr_oob); end
        n_checks++; if (rd_log[10] !== 8'h00) begin n_fail++; $display("FAIL basic_src_addr10: got %h want 00", rd_log[10]); end
        for (int k = 0; k < 7; k++) begin
            n_checks++;
            if (ct_mem[k] !== hand[k]) begin n_fail++; $display("FAIL basic_hand[%0d]: got %h want %h", k, ct_mem[k], hand[k]); end
        end
        for (int k = 0; k < 64; k++) begin
            n_checks++;
            if (ct_mem[k] !== exp_ct[k]) begin n_fail++; $display("FAIL basic_model[%0d]: got %h want %h", k, ct_mem[k], exp_ct[k]); end
        end
    endtask

    task automatic test_parity_pattern();
        int         lat;
        logic [7:0] hand [3];
        hand = '{8'h21, 8'h22, 8'hA5};
        set_key(8'h0C, 8'h7E, 8'h01);
        build_model(4'd12, 7'h7E, 7'h01);
        clear_ct();
        launch(lat);
        n_checks++; if (lat != 131) begin n_fail++; $display("FAIL p7e_latency: got %0d want 131", lat); end
        n_checks++; if (rd_log[12] !== 8'h00) begin n_fail++; $display("FAIL p7e_src_addr12: got %h want 00", rd_log[12]); end
        n_checks++; if (rd_log[63] !== 8'd51) begin n_fail++; $display("FAIL p7e_src_addr63: got %h want 33", rd_log[63]); end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (ct_mem[k] !== hand[k]) begin n_fail++; $display("FAIL p7e_hand[%0d]: got %h want %h", k, ct_mem[k], hand[k]); end
        end
        for (int k = 0; k < 64; k++) begin
            n_checks++;
            if (ct_mem[k] !== exp_ct[k]) begin n_fail++; $display("FAIL p7e_model[%0d]: got %h want %h", k, ct_mem[k], exp_ct[k]); end
        end
    endtask

    task automatic test_zero_init();
        int         lat;
        logic [7:0] hand [3];
        hand = '{8'h21, 8'h55, 8'h65};
        set_key(8'h01, 8'h48, 8'h01);
        build_model(4'd1, 7'h48, 7'h01);
        clear_ct();
        launch(lat);
        for (int k = 0; k < 64; k++) saved_ct[k] = ct_mem[k];
        n_checks++; if (rd_log[1] !== 8'h00) begin n_fail++; $display("FAIL zinit_src_addr1: got %h want 00", rd_log[1]); end
        n_checks++; if (rd_log[63] !== 8'd62) begin n_fail++; $display("FAIL zinit_src_addr63: got %h want 3e", rd_log[63]); end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (ct_mem[k] !== hand[k]) begin n_fail++; $display("FAIL zinit_hand[%0d]: got %h want %h", k, ct_mem[k], hand[k]); end
        end
        for (int k = 0; k < 64; k++) begin
            n_checks++;
            if (saved_ct[k] !== exp_ct[k]) begin n_fail++; $display("FAIL zinit_model[%0d]: got %h want %h", k, saved_ct[k], exp_ct[k]); end
        end
        set_key(8'h01, 8'h48, 8'h00);
        clear_ct();
        launch(lat);
        n_checks++; if (lat != 131) begin n_fail++; $display("FAIL zinit_latency: got %0d want 131", lat); end
        for (int k = 0; k < 64; k++) begin
            n_checks++;
            if (ct_mem[k] !== saved_ct[k]) begin n_fail++; $display("FAIL zinit_same[%0d]: got %h want %h", k, ct_mem[k], saved_ct[k]); end
        end
    endtask

    task automatic test_bit7();
        int lat;
        for (int k = 0; k < 61; k++) src_mem[k] = {1'b1, 7'(k * 5 + 31)};
        set_key(8'h0F, 8'h60, 8'h01);
        clear_ct();
        launch(lat);
        n_checks++; if (lat != 131) begin n_fail++; $display("FAIL bit7_latency: got %0d want 131", lat); end
        n_checks++; if (ct_mem[0] !== 8'h21) begin n_fail++; $display("FAIL bit7_pad0: got %h want 21", ct_mem[0]); end
        n_checks++; if (rd_log[15] !== 8'h00) begin n_fail++; $display("FAIL bit7_src_addr15: got %h want 00", rd_log[15]); end
        n_checks++; if (rd_log[63] !== 8'd48) begin n_fail++; $display("FAIL bit7_src_addr63: got %h want 30", rd_log[63]); end
        for (int k = 0; k < 64; k++) begin
            saved_ct[k] = ct_mem[k];
            n_checks++;
            if (ct_mem[k][7] !== ^ct_mem[k][6:0]) begin
                n_fail++; $display("FAIL bit7_parity[%0d]: got byte %h, bit7 should be %b", k, ct_mem[k], ^ct_mem[k][6:0]);
            end
        end
        for (int k = 0; k < 61; k++) src_mem[k][7] = 1'b0;
        build_model(4'd15, 7'h60, 7'h01);
        clear_ct();
        launch(lat);
        for (int k = 0; k < 64; k++) begin
            n_checks++;
            if (ct_mem[k] !== saved_ct[k] || ct_mem[k] !== exp_ct[k]) begin
                n_fail++; $display("FAIL bit7_ignored[%0d]: got %h / %h want %h", k, ct_mem[k], saved_ct[k], exp_ct[k]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        bit reached;
        set_msg("Wads has worked once again");
        set_key(8'hFA, 8'hE0, 8'h81);
        build_model(4'd10, 7'h60, 7'h01);
        clear_ct();
        @(negedge Clk);
        Start = 1'b1;
        repeat (2) @(negedge Clk);
        Start = 1'b0;
        reached = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(posedge Clk);
            #1;
            if (wr_count == 30) begin reached = 1'b1; break; end
        end
        n_checks++; if (!reached) begin n_fail++; $display("FAIL midrun_reach30: got %0d writes want 30", wr_count); end
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        n_checks++; if (Ack !== 1'b0) begin n_fail++; $display("FAIL midrun_ack: got %b want 0", Ack); end
        n_checks++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL midrun_wr_en: got %b want 0", mem_wr_en); end
        n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL midrun_idle_addr: got %h want 00", mem_addr); end
        @(negedge Clk);
        Reset = 1'b1;
        repeat (20) @(negedge Clk);
        n_checks++; if (wr_count != 30) begin n_fail++; $display("FAIL midrun_no_launch: got %0d writes want 30", wr_count); end
        n_checks++; if (Ack !== 1'b0) begin n_fail++; $display("FAIL midrun_idle_ack: got %b want 0", Ack); end
        clear_ct();
        launch(lat);
        n_checks++; if (lat != 131) begin n_fail++; $display("FAIL midrun_latency: got %0d want 131", lat); end
        n_checks++; if (wr_count != 64) begin n_fail++; $display("FAIL midrun_writes: got %0d want 64", wr_count); end
        for (int k = 0; k < 64; k++) begin
            n_checks++;
            if (ct_mem[k] !== exp_ct[k]) begin n_fail++; $display("FAIL midrun_model[%0d]: got %h want %h", k, ct_mem[k], exp_ct[k]); end
        end
    endtask

    task automatic test_hold_ack();
        int lat;
        bit dropped;
        bit stray_wr;
        set_key(8'h00, 8'h60, 8'h05);
        build_model(4'd0, 7'h60, 7'h05);
        clear_ct();
        launch(lat);
        n_checks++; if (lat != 131) begin n_fail++; $display("FAIL hold_latency: got %0d want 131", lat); end
        n_checks++; if (ct_mem[0] !== 8'hD2) begin n_fail++; $display("FAIL hold_pre0_byte0: got %h want d2", ct_mem[0]); end
        n_checks++; if (rd_log[63] !== 8'd63) begin n_fail++; $display("FAIL hold_src_addr63: got %h want 3f", rd_log[63]); end
        for (int k = 0; k < 64; k++) begin
            n_checks++;
            if (ct_mem[k] !== exp_ct[k]) begin n_fail++; $display("FAIL hold_model[%0d]: got %h want %h", k, ct_mem[k], exp_ct[k]); end
        end
        dropped  = 1'b0;
        stray_wr = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge Clk);
            if (Ack !== 1'b1) dropped = 1'b1;
            if (mem_wr_en !== 1'b0) stray_wr = 1'b1;
        end
        n_checks++; if (dropped) begin n_fail++; $display("FAIL hold_ack_kept: Ack dropped, want held at 1"); end
        n_checks++; if (stray_wr || wr_count != 64) begin n_fail++; $display("FAIL hold_no_rerun: got %0d writes want 64", wr_count); end
        Start = 1'b1;
        @(posedge Clk);
        #1;
        n_checks++; if (Ack !== 1'b0) begin n_fail++; $display("FAIL hold_ack_clear: got %b want 0", Ack); end
    endtask

    initial begin
        Reset = 1'b0;
        Start = 1'b1;
        for (int k = 0; k < 64; k++) begin
            src_mem[k] = 8'h00;
            rd_log[k]  = 8'hFF;
        end
        test_reset();
        test_basic();
        test_parity_pattern();
        test_zero_init();
        test_bit7();
        test_reset_midrun();
        test_hold_ack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
